// File: rtl/matmul_engine_pkg.sv
// Shared definitions for the matrix-multiply engine: FSM states, bank select codes
// and the address-width helper.
package matmul_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;

  // A bank of N*N words needs at least one address bit, even for N=1.
  function automatic int addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matmul_engine_bank.sv
// Register-file bank: async-cleared words, one synchronous write port and one
// combinational read port. Addresses at or beyond DEPTH are ignored on write and read as 0.
module matmul_engine_bank #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        if (we_i && (waddr_i == AW'(w))) begin
          mem_q[w] <= wdata_i;
        end
      end
    end
  end

  // Decoded mux so an out-of-range address never indexes past the array.
  always_comb begin
    rdata_o = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (raddr_i == AW'(w)) begin
        rdata_o = mem_q[w];
      end
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// NxN unsigned matrix multiplier C = A x B (mod 2^DW): host-loaded A/B banks,
// self-sequenced CLEAR/MAC/WRITE loop per element, registered C read port.
module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int AW = addr_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int            DEPTH = N * N;
  localparam logic [AW-1:0] N_A   = AW'(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] rd_data_q;

  logic          a_we, b_we, c_we;
  logic [AW-1:0] a_raddr, b_raddr, c_waddr;
  logic [DW-1:0] a_rdata, b_rdata, c_rdata;
  logic [DW-1:0] prod;

  // Host writes only land while idle, so operands are frozen during compute.
  assign a_we = (state_q == ST_IDLE) && wr_en && (wr_sel == SEL_A);
  assign b_we = (state_q == ST_IDLE) && wr_en && (wr_sel == SEL_B);

  assign a_raddr = i_q * N_A + k_q;
  assign b_raddr = k_q * N_A + j_q;
  assign c_waddr = i_q * N_A + j_q;
  assign prod    = a_rdata * b_rdata;

  matmul_engine_bank #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .we_i    (a_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (a_raddr),
    .rdata_o (a_rdata)
  );

  matmul_engine_bank #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .we_i    (b_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (b_raddr),
    .rdata_o (b_rdata)
  );

  matmul_engine_bank #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_bank_c (
    .clk     (clk),
    .rst     (rst),
    .we_i    (c_we),
    .waddr_i (c_waddr),
    .wdata_i (acc_q),
    .raddr_i (rd_addr),
    .rdata_o (c_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      rd_data_q <= c_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      ST_CLEAR: begin
        acc_d   = '0;
        k_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_q + prod;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WRITE: begin
        c_we    = 1'b1;
        state_d = ST_CLEAR;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == ST_CLEAR) || (state_q == ST_MAC) || (state_q == ST_WRITE);
  assign done    = (state_q == ST_DONE);
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench: stimulus pushes expected C words computed from a plain
// matrix-product model; negedge monitors pop and compare the registered read data.
module tb_matmul_engine;

  localparam int N   = 2;
  localparam int AW  = 2;
  localparam int NN  = 4;
  localparam int BSY = NN * (N + 2);
  localparam int N3  = 3;
  localparam int AW3 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = 2'd0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;

  logic           wr_en3 = 1'b0;
  logic [1:0]     wr_sel3 = 2'd0;
  logic [AW3-1:0] wr_addr3 = '0;
  logic [31:0]    wr_data3 = '0;
  logic           start3 = 1'b0;
  logic           busy3, done3;
  logic [AW3-1:0] rd_addr3 = '0;
  logic [31:0]    rd_data3;

  always #5 clk = ~clk;

  matmul_engine #(.N(N), .DW(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  matmul_engine #(.N(N3), .DW(32)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .start(start3), .busy(busy3), .done(done3),
    .rd_addr(rd_addr3), .rd_data(rd_data3)
  );

  int errors = 0;
  int checks = 0;

  // Reference operand matrices: index 0 models dut (N=2), index 1 models dut3 (N=3).
  logic [31:0] ma [2][16];
  logic [31:0] mb [2][16];

  logic [31:0] exp_q [$];
  int          exp_a [$];
  logic [31:0] exp3_q [$];
  int          exp3_a [$];
  logic rd_tag = 1'b0, rd_tag_q = 1'b0;
  logic rd3_tag = 1'b0, rd3_tag_q = 1'b0;

  function automatic logic [31:0] ref_c(input int d, input int n, input int i, input int j);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < n; k++) s = s + ma[d][i*n+k] * mb[d][k*n+j];
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    rd_tag_q  <= rd_tag;
    rd3_tag_q <= rd3_tag;
  end

  always @(negedge clk) begin
    if (rd_tag_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_c unexpected read got=%0h", rd_data);
      end else begin
        logic [31:0] e;
        int a;
        e = exp_q.pop_front();
        a = exp_a.pop_front();
        $display("read C[%0d] got=%0h want=%0h", a, rd_data, e);
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_c[%0d] got=%0h want=%0h", a, rd_data, e);
        end
      end
    end
    if (rd3_tag_q) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL rd3_c unexpected read got=%0h", rd_data3);
      end else begin
        logic [31:0] e;
        int a;
        e = exp3_q.pop_front();
        a = exp3_a.pop_front();
        $display("read3 C[%0d] got=%0h want=%0h", a, rd_data3, e);
        if (rd_data3 !== e) begin
          errors++;
          $display("FAIL rd3_c[%0d] got=%0h want=%0h", a, rd_data3, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_ab(input logic [1:0] sel, input int addr, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[AW-1:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel == 2'd0) ma[0][addr] = d;
    else if (sel == 2'd1) mb[0][addr] = d;
  endtask

  task automatic load(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    write_ab(2'd0, 0, a0); write_ab(2'd0, 1, a1);
    write_ab(2'd0, 2, a2); write_ab(2'd0, 3, a3);
    write_ab(2'd1, 0, b0); write_ab(2'd1, 1, b1);
    write_ab(2'd1, 2, b2); write_ab(2'd1, 3, b3);
  endtask

  task automatic read_all;
    int off;
    off = $urandom_range(0, NN - 1);
    for (int n = 0; n < NN; n++) begin
      int a;
      a = (n + off) % NN;
      rd_addr = a[AW-1:0];
      rd_tag  = 1'b1;
      exp_q.push_back(ref_c(0, N, a / N, a % N));
      exp_a.push_back(a);
      tick();
    end
    rd_tag = 1'b0;
    tick();
    tick();
  endtask

  // Runs one compute; optionally hits it with start + B[0]=99 at a busy cycle
  // and with start in the DONE cycle, none of which may have any effect.
  task automatic run(input bit inject, input int inj_cycle);
    int bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    bad   = 0;
    for (int c = 1; c <= BSY; c++) begin
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      if (inject && c == inj_cycle) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_addr = '0; wr_data = 32'd99;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    chk("busy_window_bad_cycles", 32'(bad), 32'd0);
    chk("done_pulse_busy_done", 32'({busy, done}), 32'd1);
    if (inject) start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_done_busy_done", 32'({busy, done}), 32'd0);
    tick();
    chk("idle_after_done_busy", 32'(busy), 32'd0);
    $display("compute done inject=%0d", inject);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) begin
        ma[d][w] = 32'd0;
        mb[d][w] = 32'd0;
      end

    // Asynchronous reset asserted between clock edges takes effect at once.
    #2 rst = 1'b1;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    read_all();

    // Identity B.
    load(1, 2, 3, 4, 1, 0, 0, 1);
    run(1'b0, 0);
    read_all();

    // General product -> 19,22,43,50.
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run(1'b0, 0);
    read_all();

    // Wraparound mod 2^32.
    load(32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0, 0);
    run(1'b0, 0);
    read_all();

    // start and B writes during compute/DONE are ignored.
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run(1'b1, 7);
    read_all();
    run(1'b0, 0);
    read_all();

    // Mid-compute async reset: outputs drop immediately and no done follows.
    rd_addr = 2'd3;
    tick();
    tick();
    chk("rd_data_before_reset", rd_data, ref_c(0, N, 1, 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_busy", 32'(busy), 32'd0);
    chk("midop_reset_done", 32'(done), 32'd0);
    chk("midop_reset_rd_data", rd_data, 32'd0);
    for (int w = 0; w < 16; w++) begin
      ma[0][w] = 32'd0;
      mb[0][w] = 32'd0;
    end
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
        if (done !== 1'b0 || busy !== 1'b0) seen++;
        tick();
      end
      chk("no_done_after_reset", 32'(seen), 32'd0);
    end
    read_all();
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run(1'b0, 0);
    read_all();

    // Writes coinciding with start commit and are used; sel 2/3 writes are dropped.
    write_ab(2'd2, 1, 32'd123);
    write_ab(2'd3, 2, 32'd456);
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 2'd1; wr_data = 32'd10;
    ma[0][1] = 32'd10;
    run(1'b0, 0);
    read_all();

    // Randomized operands, mixing full-range and small values.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] v [8];
      for (int w = 0; w < 8; w++)
        v[w] = (r % 2 == 0) ? $urandom() : 32'($urandom_range(0, 15));
      load(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
      if ($urandom_range(0, 1) == 1) write_ab(2'd3, 0, $urandom());
      run(1'b0, 0);
      read_all();
    end

    // N=3 identity x identity, done in the 46th cycle after start.
    for (int w = 0; w < 9; w++) begin
      wr_en3 = 1'b1;
      wr_sel3 = 2'd0; wr_addr3 = w[AW3-1:0]; wr_data3 = (w % 4 == 0) ? 32'd1 : 32'd0;
      ma[1][w] = wr_data3;
      tick();
      wr_sel3 = 2'd1;
      mb[1][w] = wr_data3;
      tick();
    end
    wr_en3 = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    begin
      int cyc, bcnt;
      cyc  = 1;
      bcnt = 0;
      while (done3 !== 1'b1 && cyc < 200) begin
        if (busy3 === 1'b1) bcnt++;
        tick();
        cyc++;
      end
      chk("n3_done_cycle", 32'(cyc), 32'd46);
      chk("n3_busy_cycles", 32'(bcnt), 32'd45);
      chk("n3_done_busy_low", 32'(busy3), 32'd0);
    end
    tick();
    for (int a = 0; a < 11; a++) begin
      int ad;
      ad = (a < 9) ? a : ((a == 9) ? 12 : 15);
      rd_addr3 = ad[AW3-1:0];
      rd3_tag  = 1'b1;
      exp3_q.push_back((ad < 9) ? ref_c(1, N3, ad / N3, ad % N3) : 32'd0);
      exp3_a.push_back(ad);
      tick();
    end
    rd3_tag = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size() + exp3_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
